// File: rtl/flipper_pkg.sv
// Shared flipper geometry and state encoding for the right flipper and a
// future left-flipper variant, which mirrors the tip by negating DX.
package flipper_pkg;

    typedef enum logic [1:0] {
        REST    = 2'd0,
        RISING  = 2'd1,
        UP_HOLD = 2'd2,
        FALLING = 2'd3
    } flipper_state_e;

    localparam int FLIPPER_STEPS  = 8;
    localparam int FLIPPER_LENGTH = 60;

    // Tip offsets from the pivot, step 0 = rest (30 deg down), step 7 = horizontal.
    localparam logic [0:7][5:0] FLIPPER_DX = {
        6'd52, 6'd54, 6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'(FLIPPER_LENGTH)
    };
    localparam logic [0:7][5:0] FLIPPER_DY = {
        6'd30, 6'd26, 6'd22, 6'd18, 6'd13, 6'd9, 6'd4, 6'd0
    };

    function automatic logic [5:0] tip_dx(input logic [2:0] step);
        return FLIPPER_DX[step];
    endfunction

    function automatic logic [5:0] tip_dy(input logic [2:0] step);
        return FLIPPER_DY[step];
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous flipper key, resets to 0.
module key_sync (
    input  logic clk,
    input  logic resetN,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Double-register the raw key level into the clk domain.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/flipper_motion_ctrl.sv
// Right-flipper motion controller: turns the flipper key into an animated
// tip coordinate (X1, Y1) about the pivot (XC, YC), one step per tick.
// Optional hold time limit in UP_HOLD: define FLIPPER_HOLD_LIMIT_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  REST    | flipper down, step 0
//  RISING  | swinging up, step 1..6, collision kick allowed
//  UP_HOLD | fully up, step 7, key still held
//  FALLING | swinging down after release, step 1..6
module flipper_motion_ctrl
    import flipper_pkg::*;
#(
    parameter int XC              = 455,
    parameter int YC              = 400,
    parameter int FRAMES_PER_STEP = 1,
    parameter int HOLD_MAX_FRAMES = 90
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               keyPressed,
    output logic signed [10:0] X1,
    output logic signed [10:0] Y1,
    output logic               flipperRising,
    output logic [2:0]         flipperStep
);

    localparam logic [1:0] ST_REST    = REST;
    localparam logic [1:0] ST_RISING  = RISING;
    localparam logic [1:0] ST_UP_HOLD = UP_HOLD;
    localparam logic [1:0] ST_FALLING = FALLING;

    localparam logic [2:0] STEP_TOP = 3'(FLIPPER_STEPS - 1);

    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

    localparam logic signed [10:0] XC_S = 11'(XC);
    localparam logic signed [10:0] YC_S = 11'(YC);

    logic               w_key_s;
    logic               w_key_eff;
    logic               w_tick;
    logic               w_hold_force;
    logic [1:0]         w_state_next;
    logic [2:0]         w_step_next;
    logic signed [10:0] w_x_next;
    logic signed [10:0] w_y_next;

    logic [FCW-1:0]     r_frame_cnt;
    logic [1:0]         r_state;
    logic [2:0]         r_step;
    logic signed [10:0] r_x1;
    logic signed [10:0] r_y1;
    logic               r_rising;

    key_sync u_key_sync (
        .clk     (clk),
        .resetN  (resetN),
        .i_async (keyPressed),
        .o_sync  (w_key_s)
    );

    assign w_tick = startOfFrame && (r_frame_cnt == FC_LAST);

    // Divide startOfFrame pulses down to one animation tick per FRAMES_PER_STEP.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_cnt <= '0;
        end else if (startOfFrame) begin
            r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
    end

`ifdef FLIPPER_HOLD_LIMIT_EN
    localparam int HCW = $clog2(HOLD_MAX_FRAMES + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(HOLD_MAX_FRAMES);

    logic [HCW-1:0] r_hold_cnt;
    logic           r_lockout;

    assign w_hold_force = (r_state == ST_UP_HOLD) && (r_hold_cnt >= HOLD_MAX);
    assign w_key_eff    = w_key_s && !r_lockout;

    // Count frames spent up; saturate so long ticks cannot wrap the count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hold_cnt <= '0;
        end else if (w_state_next != ST_UP_HOLD) begin
            r_hold_cnt <= '0;
        end else if (startOfFrame && r_state == ST_UP_HOLD && r_hold_cnt < HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // Ignore the key after a forced drop until the player lets go once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lockout <= 1'b0;
        end else if (w_tick && w_hold_force) begin
            r_lockout <= 1'b1;
        end else if (!w_key_s) begin
            r_lockout <= 1'b0;
        end
    end
`else
    // Hold limit disabled: the comparison is constant false.
    assign w_hold_force = (HOLD_MAX_FRAMES < 0);
    assign w_key_eff    = w_key_s;
`endif

    // Next state and step, only moving on a tick and one step at a time.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        if (w_tick) begin
            case (r_state)
                ST_REST: begin
                    if (w_key_eff) begin
                        w_state_next = ST_RISING;
                        w_step_next  = 3'd1;
                    end
                end
                ST_RISING, ST_FALLING: begin
                    if (w_key_eff) begin
                        w_step_next  = r_step + 3'd1;
                        w_state_next = (r_step == STEP_TOP - 3'd1) ? ST_UP_HOLD : ST_RISING;
                    end else begin
                        w_step_next  = r_step - 3'd1;
                        w_state_next = (r_step == 3'd1) ? ST_REST : ST_FALLING;
                    end
                end
                ST_UP_HOLD: begin
                    if (w_hold_force || !w_key_eff) begin
                        w_state_next = ST_FALLING;
                        w_step_next  = STEP_TOP - 3'd1;
                    end
                end
                default: begin
                    w_state_next = ST_REST;
                    w_step_next  = 3'd0;
                end
            endcase
        end
    end

    assign w_x_next = XC_S - $signed({5'b0, tip_dx(w_step_next)});
    assign w_y_next = YC_S + $signed({5'b0, tip_dy(w_step_next)});

    // Register state and all outputs together from the next values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= ST_REST;
            r_step   <= 3'd0;
            r_x1     <= XC_S - $signed({5'b0, tip_dx(3'd0)});
            r_y1     <= YC_S + $signed({5'b0, tip_dy(3'd0)});
            r_rising <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_step   <= w_step_next;
            r_x1     <= w_x_next;
            r_y1     <= w_y_next;
            r_rising <= (w_state_next == ST_RISING);
        end
    end

    assign X1            = r_x1;
    assign Y1            = r_y1;
    assign flipperRising = r_rising;
    assign flipperStep   = r_step;

endmodule

// File: tb/tb_flipper_motion_ctrl.sv
// Testbench for flipper_motion_ctrl: stimulus pushes expected tip/step/rising
// per frame pulse into a queue; per-DUT monitors pop and compare.
module tb_flipper_motion_ctrl;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof_a = 1'b0, key_a = 1'b0;
    logic sof_b = 1'b0, key_b = 1'b0;

    logic signed [10:0] x1_a, y1_a, x1_b, y1_b;
    logic               rise_a, rise_b;
    logic [2:0]         step_a, step_b;

    typedef struct packed {
        logic signed [10:0] x;
        logic signed [10:0] y;
        logic [2:0]         step;
        logic               rising;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a, last_b;

    int n_pass = 0;
    int n_total = 0;

    int dx_t [8] = '{52, 54, 56, 57, 58, 59, 60, 60};
    int dy_t [8] = '{30, 26, 22, 18, 13, 9, 4, 0};

    always #5 clk = ~clk;

    flipper_motion_ctrl #(
        .XC(455), .YC(400), .FRAMES_PER_STEP(1), .HOLD_MAX_FRAMES(5)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof_a), .keyPressed(key_a),
        .X1(x1_a), .Y1(y1_a), .flipperRising(rise_a), .flipperStep(step_a)
    );

    flipper_motion_ctrl #(
        .XC(455), .YC(400), .FRAMES_PER_STEP(3), .HOLD_MAX_FRAMES(5)
    ) dut3 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof_b), .keyPressed(key_b),
        .X1(x1_b), .Y1(y1_b), .flipperRising(rise_b), .flipperStep(step_b)
    );

    function automatic exp_t raw(input int x, input int y, input int step, input bit rising);
        exp_t e;
        e.x = 11'(x);
        e.y = 11'(y);
        e.step = 3'(step);
        e.rising = rising;
        return e;
    endfunction

    function automatic exp_t mk(input int step, input bit rising);
        return raw(455 - dx_t[step], 400 + dy_t[step], step, rising);
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got X1=%0d Y1=%0d step=%0d rising=%0d, expected X1=%0d Y1=%0d step=%0d rising=%0d",
                      name, act.x, act.y, act.step, act.rising, req.x, req.y, req.step, req.rising);
    endtask

    // Monitor for the FRAMES_PER_STEP=1 instance.
    initial begin
        exp_t cur, e;
        last_a = raw(403, 430, 0, 0);
        forever begin
            @(negedge clk);
            if (!resetN) begin
                last_a = raw(403, 430, 0, 0);
            end else if (sof_a) begin
                cur = {x1_a, y1_a, step_a, rise_a};
                check("a_unchanged_in_tick_cycle", cur, last_a);
                @(negedge clk);
                cur = {x1_a, y1_a, step_a, rise_a};
                if (q_a.size() == 0) begin
                    n_total++;
                    $display("FAIL a_queue_underflow: got empty queue, expected an entry");
                end else begin
                    e = q_a.pop_front();
                    check("a_after_tick", cur, e);
                    last_a = e;
                end
            end
        end
    end

    // Monitor for the FRAMES_PER_STEP=3 instance.
    initial begin
        exp_t cur, e;
        last_b = raw(403, 430, 0, 0);
        forever begin
            @(negedge clk);
            if (!resetN) begin
                last_b = raw(403, 430, 0, 0);
            end else if (sof_b) begin
                cur = {x1_b, y1_b, step_b, rise_b};
                check("b_unchanged_in_pulse_cycle", cur, last_b);
                @(negedge clk);
                cur = {x1_b, y1_b, step_b, rise_b};
                if (q_b.size() == 0) begin
                    n_total++;
                    $display("FAIL b_queue_underflow: got empty queue, expected an entry");
                end else begin
                    e = q_b.pop_front();
                    check("b_after_pulse", cur, e);
                    last_b = e;
                end
            end
        end
    end

    task automatic frame_a(input exp_t e);
        @(posedge clk); #2 sof_a = 1'b1;
        q_a.push_back(e);
        @(posedge clk); #2 sof_a = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic frame_b(input exp_t e);
        @(posedge clk); #2 sof_b = 1'b1;
        q_b.push_back(e);
        @(posedge clk); #2 sof_b = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic set_key_a(input bit v);
        #2 key_a = v;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t cur;
        // Reset values
        repeat (3) @(posedge clk);
        #1 cur = {x1_a, y1_a, step_a, rise_a};
        check("reset_a", cur, raw(403, 430, 0, 0));
        cur = {x1_b, y1_b, step_b, rise_b};
        check("reset_b", cur, raw(403, 430, 0, 0));
        #1 resetN = 1'b1;
        repeat (3) @(posedge clk);

        // Full swing up with key held, including a short bounce in UP_HOLD
        set_key_a(1);
        for (int s = 1; s <= 6; s++) frame_a(mk(s, 1));
        frame_a(raw(395, 400, 7, 0));
        frame_a(mk(7, 0));
        #2 key_a = 1'b0;
        @(posedge clk); #2 key_a = 1'b1;
        repeat (4) @(posedge clk);
        frame_a(mk(7, 0));

        // Release from UP_HOLD down to REST
        set_key_a(0);
        for (int s = 6; s >= 1; s--) frame_a(mk(s, 0));
        frame_a(raw(403, 430, 0, 0));
        frame_a(mk(0, 0));

        // Release after step 4
        set_key_a(1);
        for (int s = 1; s <= 3; s++) frame_a(mk(s, 1));
        frame_a(raw(397, 413, 4, 1));
        set_key_a(0);
        for (int s = 3; s >= 1; s--) frame_a(mk(s, 0));
        frame_a(raw(403, 430, 0, 0));

        // Re-press while FALLING at step 2
        set_key_a(1);
        for (int s = 1; s <= 4; s++) frame_a(mk(s, 1));
        set_key_a(0);
        frame_a(mk(3, 0));
        frame_a(mk(2, 0));
        set_key_a(1);
        frame_a(mk(3, 1));
        frame_a(mk(4, 1));

        // Asynchronous reset mid-swing
        #3 resetN = 1'b0;
        #1 cur = {x1_a, y1_a, step_a, rise_a};
        check("reset_mid_swing", cur, raw(403, 430, 0, 0));
        @(posedge clk); #2 resetN = 1'b1;
        repeat (4) @(posedge clk);
        frame_a(mk(1, 1));
        set_key_a(0);
        frame_a(mk(0, 0));

        // FRAMES_PER_STEP=3: step moves only on every third pulse
        #2 key_b = 1'b1;
        repeat (4) @(posedge clk);
        frame_b(mk(0, 0)); frame_b(mk(0, 0)); frame_b(mk(1, 1));
        frame_b(mk(1, 1)); frame_b(mk(1, 1)); frame_b(mk(2, 1));
        frame_b(mk(2, 1)); frame_b(mk(2, 1)); frame_b(mk(3, 1));

`ifdef FLIPPER_HOLD_LIMIT_EN
        // Hold limit of 5 frames, then lockout until key released
        set_key_a(1);
        for (int s = 1; s <= 6; s++) frame_a(mk(s, 1));
        frame_a(mk(7, 0));
        for (int f = 0; f < 5; f++) frame_a(mk(7, 0));
        for (int s = 6; s >= 1; s--) frame_a(mk(s, 0));
        frame_a(mk(0, 0));
        frame_a(mk(0, 0));
        frame_a(mk(0, 0));
        set_key_a(0);
        frame_a(mk(0, 0));
        set_key_a(1);
        frame_a(mk(1, 1));
        frame_a(mk(2, 1));
`endif

        repeat (5) @(posedge clk);
        n_total++;
        if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
        else $display("FAIL queues_drained: got %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
